// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory-controller port between the iport (read-only) and dport (read/write).
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break via last_grant; default build gives dport fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [1:0]              i_rw_flag,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_read_data,
  output logic                    i_busy,
  output logic                    i_done,
  input  logic [1:0]              d_rw_flag,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_write_data,
  input  logic [DATA_WIDTH/8-1:0] d_write_mask,
  output logic [DATA_WIDTH-1:0]   d_read_data,
  output logic                    d_busy,
  output logic                    d_done,
  output logic [1:0]              mem_rw_flag,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_write_mask,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic                    mem_busy,
  input  logic                    mem_done
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;

  logic                  i_pend;
  logic [ADDR_WIDTH-1:0] i_addr_q;
  logic                  d_pend;
  logic                  d_wr_q;
  logic [ADDR_WIDTH-1:0] d_addr_q;
  logic [DATA_WIDTH-1:0] d_wdata_q;
  logic [MW-1:0]         d_mask_q;
  logic                  owner_d;
  logic                  grant;
  logic                  grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_d;
`endif

  // The controller sequences itself on mem_done; its busy flag and iport bit1 carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{mem_busy, i_rw_flag[1]};

  assign i_busy = i_pend;
  assign d_busy = d_pend;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend || d_pend) begin
          grant     = 1'b1;
          state_nxt = WAIT;
          if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = !last_d;
`else
            grant_d = 1'b1;
`endif
          end else begin
            grant_d = d_pend;
          end
        end
      end
      WAIT: begin
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i_pend         <= 1'b0;
      i_addr_q       <= '0;
      d_pend         <= 1'b0;
      d_wr_q         <= 1'b0;
      d_addr_q       <= '0;
      d_wdata_q      <= '0;
      d_mask_q       <= '0;
      owner_d        <= 1'b0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      i_read_data    <= '0;
      d_read_data    <= '0;
      mem_rw_flag    <= 2'b00;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_mask <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d         <= 1'b1;
`endif
    end else if (rdy_in) begin
      i_done <= 1'b0;
      d_done <= 1'b0;

      // A slot only accepts while empty, so capture never collides with the completion clear.
      if (!i_pend && i_rw_flag[0]) begin
        i_pend   <= 1'b1;
        i_addr_q <= i_addr;
      end
      if (!d_pend && (d_rw_flag != 2'b00)) begin
        d_pend    <= 1'b1;
        d_wr_q    <= (d_rw_flag == 2'b10);
        d_addr_q  <= d_addr;
        d_wdata_q <= d_write_data;
        d_mask_q  <= d_write_mask;
      end

      if (grant) begin
        owner_d        <= grant_d;
        mem_rw_flag    <= (grant_d && d_wr_q) ? 2'b10 : 2'b01;
        mem_addr       <= grant_d ? d_addr_q : i_addr_q;
        mem_write_data <= grant_d ? d_wdata_q : '0;
        mem_write_mask <= grant_d ? d_mask_q : '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d         <= grant_d;
`endif
      end

      if (state == WAIT) begin
        mem_rw_flag <= 2'b00;
        if (mem_done) begin
          if (owner_d) begin
            d_done <= 1'b1;
            d_pend <= 1'b0;
            if (!d_wr_q) d_read_data <= mem_read_data;
          end else begin
            i_done      <= 1'b1;
            i_pend      <= 1'b0;
            i_read_data <= mem_read_data;
          end
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single memory-controller port between the instruction cache (iport, read-only) and the data cache (dport, read/write).
- Each port uses the same request/complete protocol that the caches already drive toward memory: one-cycle request pulse on rw_flag, then busy until a one-cycle done pulse.
- Latches each port's request, grants one at a time, issues it downstream as a one-cycle mem_rw_flag pulse, and waits for mem_done.
- Routes the completion (done, read_data) back to the owning port.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of read/write data buses; mask width is DATA_WIDTH/8.

Ports:
- clk_in  input  1  clock; every register updates on the rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global ready; when low, every register holds its value.
- i_rw_flag  input  2  iport request; bit0 = read; bit1 is ignored.
- i_addr  input  ADDR_WIDTH  iport address.
- i_read_data  output  DATA_WIDTH  iport read data; valid while i_done=1.
- i_busy  output  1  iport request pending or in flight.
- i_done  output  1  iport completion pulse, one cycle.
- d_rw_flag  input  2  dport request; 1 = read, 2 = write, 3 = treated as read.
- d_addr  input  ADDR_WIDTH  dport address.
- d_write_data  input  DATA_WIDTH  dport write data.
- d_write_mask  input  DATA_WIDTH/8  dport byte enables.
- d_read_data  output  DATA_WIDTH  dport read data; valid while d_done=1.
- d_busy  output  1  dport request pending or in flight.
- d_done  output  1  dport completion pulse, one cycle.
- mem_rw_flag  output  2  downstream request pulse.
- mem_addr  output  ADDR_WIDTH  downstream address.
- mem_write_data  output  DATA_WIDTH  downstream write data.
- mem_write_mask  output  DATA_WIDTH/8  downstream byte enables.
- mem_read_data  input  DATA_WIDTH  downstream read data; valid with mem_done.
- mem_busy  input  1  downstream busy; informational only, not used for sequencing.
- mem_done  input  1  downstream completion pulse.

Behaviour:
- Clock and reset: one clock, clk_in; rst_in is synchronous and active-high.
- Reset values: every output is 0; state = IDLE; both pending slots are empty.
- Gating: all actions below occur only on edges where rdy_in=1. With rdy_in=0, all registers hold, mem_done is not sampled, and the downstream controller stalls on the same rdy_in.
- Request capture:
  - A port with busy=0 and rw_flag!=0 in cycle n is latched (flag, addr, data, mask) at the edge ending cycle n; that port's busy=1 from cycle n+1.
  - rw_flag while busy=1 is ignored. Requesters must not issue while busy.
  - Capture is also allowed in the same cycle that port's done=1, since busy=0 in that cycle.
- State machine (2 states, registered):
  - IDLE: if any slot is pending, select the winner combinationally. At the next edge: load mem_* from the winner's slot (mem_rw_flag = 1 for read, 2 for write), record the owner, go to WAIT.
  - WAIT, first cycle: mem_rw_flag is nonzero for exactly this cycle. It is cleared at the next edge; mem_addr/data/mask hold for the whole of WAIT.
  - WAIT, completion: when mem_done=1 in cycle k, at the edge ending k the owner gets done=1 and busy=0 for cycle k+1.
    - For a read, the owner's read_data = mem_read_data.
    - For a write, read_data keeps its old value.
    - The owner's slot is cleared; state returns to IDLE.
- Completion outputs: done pulses last exactly one cycle. read_data holds until the next read completion on that port.
- Latency and throughput:
  - Request in cycle n → mem_rw_flag in cycle n+2 (one capture edge, one arbitration edge).
  - mem_done in cycle k → done in cycle k+1.
  - Minimum gap between two downstream issues is one IDLE cycle.
- Simultaneous events:
  - Both slots pending in IDLE: resolved by the priority rule (see Optional Feature).
  - The loser stays pending and is issued immediately after the winner completes.
  - mem_done while in IDLE is ignored.
- Reset mid-transaction: all slots and outputs clear at that edge and any in-flight transaction is dropped. The memory controller shares rst_in.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Without it: fixed priority; dport always wins when both slots are pending.
- With it: a last_grant register, reset value dport, updates whenever a grant is made.
  - On a tie, the port not in last_grant wins, so iport wins the first tie after reset.
  - A single pending port always wins regardless of last_grant.

Test Plan:
- Iport read: i_rw_flag=1, addr 0x100 in cycle 0 → mem_rw_flag=1, mem_addr=0x100 in cycle 2 only. mem_done with data 0xDEADBEEF in cycle 5 → i_done=1, i_read_data=0xDEADBEEF in cycle 6; i_busy is 1 in cycles 1–5 and 0 in cycle 6.
- Dport write: d_rw_flag=2, addr 0x20, data 0x12345678, mask 4'b0011 → mem_rw_flag=2 with the same addr/data/mask in cycle 2. mem_done → d_done pulse; d_read_data unchanged.
- Simultaneous requests in cycle 0, fixed priority: dport issued in cycle 2. After its mem_done, iport is issued one IDLE cycle later. With ARB_ROUND_ROBIN_EN: iport first; a second tie goes to dport.
- Back-to-back: dport re-requests in the same cycle d_done=1 → accepted; d_busy=1 in the next cycle; no lost or duplicate mem_rw_flag pulse.
- rdy_in held low for 3 cycles during WAIT with mem_done=1 asserted → no done. Completion occurs only after rdy_in returns high with mem_done=1; outputs frozen throughout the stall.
- rst_in=1 for one cycle while in WAIT → all outputs 0 in the following cycle, both busy=0, a new request is served normally, and a stale mem_done in IDLE produces no done.
